dm_ctrl: RTL and testbench
==========================

# dm_ctrl

Load/store initiator for the 4 KB data memory in the multicycle CPU. Accepts one byte, halfword or word request at a time over a valid/ready handshake and checks alignment, size and address range. Drives the memory's word address, byte enables, write data, write strobe and sign/zero select, waits out the memory's one-cycle registered read, and returns the extended load data or an error code over a valid/ready response handshake.

## Interface
- ADDR_BASE, 32'h0000_0000: base of the data memory window; only bits [31:12] are compared.
- clk  in  1  rising-edge clock shared with data memory
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size
- dm_addr  out  10  word address = addr[11:2]
- dm_be  out  4  byte enables
- dm_din  out  32  write data to memory
- dm_wr  out  1  write strobe
- dm_op  out  1  0 sign-extend, 1 zero-extend
- dm_dout  in  32  memory read data, registered in memory

## Operation
- FSM states: IDLE, ACCESS, LATCH, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid, latch we/size/unsigned/addr/wdata and compute error.
  - Error priority: size==11 → 11; else misaligned (half with addr[0]=1, word with addr[1:0]≠0) → 01; else addr[31:12]≠ADDR_BASE[31:12] → 10.
  - Error → RESP, no memory access. No error → ACCESS.
- ACCESS: one cycle. Drive dm_addr, dm_be, dm_din=latched wdata unshifted, dm_op=unsigned, dm_wr=we & ~rst. → LATCH.
- LATCH: hold dm_addr/dm_be/dm_op. dm_wr=0. Capture dm_dout into resp_rdata register on loads; on stores capture 0. → RESP.
- RESP: resp_valid=1 and resp_rdata/resp_err stable. When resp_ready=1 → IDLE. No new request is accepted until the following IDLE cycle.
- Byte-enable map:
  - byte: offset 0/1/2/3 → 0001/0010/0100/1000
  - half: offset 0 → 0011, offset 2 → 1100
  - word → 1111
- Outside ACCESS/LATCH: dm_wr=0, dm_be=1111, dm_op=0, dm_addr=0, dm_din=0.
- Load extension is performed by memory; controller passes dm_dout through unmodified.

## Timing
- Reset values: req_ready=0 during the reset cycle and 1 after it. resp_valid=0, resp_rdata=0, resp_err=00, dm_wr=0, dm_be=1111, dm_addr=0, dm_din=0, dm_op=0.
- Success path: accept edge T, ACCESS in cycle T+1, LATCH in T+2, resp_valid from T+3. Minimum request-to-request spacing is 4 cycles.
- Error path: resp_valid in cycle T+1.
- Memory write occurs at the edge ending ACCESS. The read value appears on dm_dout after that edge and is sampled at the edge ending LATCH.
- resp_valid held indefinitely while resp_ready=0, with data stable.
- rst asserted in any state returns the FSM to IDLE at the next edge and drops resp_valid. rst in ACCESS suppresses dm_wr, so no partial write occurs.

## Structure
- Shared package `dm_pkg`: size codes, error codes, state encoding, BE constants.
- One combinational sub-module `dm_be_gen` (size, addr[1:0] → be, misaligned flag), reusable by the CPU's decode checks.

## Test plan
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 → dm_be=1111, dm_addr=4, resp_rdata=0xDEADBEEF, err=00, resp_valid at T+3.
- sb 0x13 data 0x80, then lb 0x13 → be=1000, rdata=0xFFFFFF80. lbu 0x13 → 0x00000080.
- sh 0x22 data 0x8001, then lh 0x22 → be=1100, rdata=0xFFFF8001. lhu → 0x00008001.
- lw 0x06 → err=01. sh 0x1001 → err=01, not 10. size 11 → err=11. All errors show resp_valid at T+1 and dm_wr never asserted.
- lw 0x1000 with ADDR_BASE=0 → err=10. Hold resp_ready=0 for 5 cycles → response stable, req_ready=0 throughout.
- Assert rst during ACCESS of sw 0x40 data 0x12345678 → FSM in IDLE next cycle, resp_valid=0; subsequent lw 0x40 returns the prior contents.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - Shared size/error/state/byte-enable definitions for the data memory controller
//
// Purpose: common constants and helpers for dm_ctrl and dm_be_gen.
// Ports:   none (package).

package dm_pkg;

    // Access size codes as presented on req_size.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    // Response error codes.
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Byte-enable patterns.
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Request fields captured on acceptance.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

    // Error code with fixed priority: illegal size, then misalignment, then range.
    function automatic logic [1:0] dm_check(input logic [1:0] size,
                                            input logic       misalign,
                                            input logic       in_range);
        if (size == SIZE_X) begin
            return ERR_SIZE;
        end else if (misalign) begin
            return ERR_MISALIGN;
        end else if (!in_range) begin
            return ERR_RANGE;
        end
        return ERR_OK;
    endfunction

endpackage

// File: rtl/dm_be_gen.sv
// rtl/dm_be_gen.sv - Byte-enable and misalignment decode from access size and address offset
//
// Purpose: combinational lane decode, shared with CPU decode-stage checks.
// Ports:
//   size_i      in  2  access size code
//   off_i       in  2  byte offset addr[1:0]
//   be_o        out 4  byte enables (1111 for word or illegal size)
//   misalign_o  out 1  offset not a multiple of the access size

module dm_be_gen
    import dm_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] off_i,
    output logic [3:0] be_o,
    output logic       misalign_o
);

    always_comb begin
        be_o       = BE_W;
        misalign_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                be_o = BE_B0 << off_i;
            end
            SIZE_H: begin
                be_o       = off_i[1] ? BE_H1 : BE_H0;
                misalign_o = off_i[0];
            end
            SIZE_W: begin
                misalign_o = |off_i;
            end
            default: begin
                // Illegal size is reported separately; lanes are don't-care.
                be_o = BE_W;
            end
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - Load/store initiator for the 4 KB data memory
//
// Purpose: accepts one load/store request, validates it, drives the data
//          memory for one access cycle, waits out the registered read and
//          returns the load data or an error code.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_we/req_size/req_unsigned   request type
//   req_addr/req_wdata             byte address, right-justified store data
//   resp_valid/resp_ready          response handshake
//   resp_rdata/resp_err            load data (0 for stores/errors), error code
//   dm_addr/dm_be/dm_din           memory word address, byte enables, write data
//   dm_wr/dm_op                    memory write strobe, zero-extend select
//   dm_dout                        memory read data (registered in memory)

module dm_ctrl
    import dm_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [9:0]  dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_din,
    output logic        dm_wr,
    output logic        dm_op,
    input  logic [31:0] dm_dout
);

    logic [1:0]  state_q, state_d;
    dm_req_t     req_q, req_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  gen_be;
    logic        gen_misalign;
    logic        in_range;
    logic [1:0]  new_err;
    logic        in_mem;

    dm_be_gen u_be_gen (
        .size_i     (req_size),
        .off_i      (req_addr[1:0]),
        .be_o       (gen_be),
        .misalign_o (gen_misalign)
    );

    assign in_range = (req_addr[31:12] == ADDR_BASE[31:12]);
    assign new_err  = dm_check(req_size, gen_misalign, in_range);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        be_d    = be_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d   = '{we: req_we, size: req_size, uns: req_unsigned,
                                addr: req_addr, wdata: req_wdata};
                    be_d    = gen_be;
                    err_d   = new_err;
                    rdata_d = 32'h0;
                    // Rejected requests skip the memory entirely.
                    state_d = (new_err != ERR_OK) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // dm_dout is already extended by the memory; stores return 0.
                rdata_d = req_q.we ? 32'h0 : dm_dout;
                state_d = ST_RESP;
            end
            default: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            be_q    <= BE_W;
            err_q   <= ERR_OK;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory-side drive is only live while an access is in flight.
    assign in_mem  = (state_q == ST_ACCESS) || (state_q == ST_LATCH);
    assign dm_addr = in_mem ? req_q.addr[11:2] : 10'h0;
    assign dm_be   = in_mem ? be_q : BE_W;
    assign dm_op   = in_mem & req_q.uns;
    assign dm_din  = in_mem ? req_q.wdata : 32'h0;
    // Gating with rst keeps a reset during ACCESS from committing a write.
    assign dm_wr   = (state_q == ST_ACCESS) & req_q.we & ~rst;

    assign req_ready  = (state_q == ST_IDLE) & ~rst;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - Self-checking bench for dm_ctrl with a behavioural data memory

module tb_dm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [9:0]  dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_din;
    logic        dm_wr, dm_op;
    logic [31:0] dm_dout;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    dm_ctrl #(.ADDR_BASE(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din),
        .dm_wr(dm_wr), .dm_op(dm_op), .dm_dout(dm_dout)
    );

    // Behavioural data memory: lane-placed writes, registered extended reads.
    logic [31:0] mem [0:1023] = '{default: 32'h0};

    function automatic int lane_lo(input logic [3:0] be);
        for (int k = 0; k < 4; k++) if (be[k]) return k;
        return 0;
    endfunction

    function automatic int lane_n(input logic [3:0] be);
        return int'(be[0]) + int'(be[1]) + int'(be[2]) + int'(be[3]);
    endfunction

    always @(posedge clk) begin
        logic [31:0] r, w;
        int lo, n;
        lo = lane_lo(dm_be);
        n  = lane_n(dm_be);
        r  = mem[dm_addr] >> (8 * lo);
        case (n)
            1:       dm_dout <= dm_op ? {24'h0, r[7:0]}   : {{24{r[7]}}, r[7:0]};
            2:       dm_dout <= dm_op ? {16'h0, r[15:0]}  : {{16{r[15]}}, r[15:0]};
            default: dm_dout <= r;
        endcase
        if (dm_wr) begin
            w = mem[dm_addr];
            for (int k = 0; k < 4; k++)
                if (dm_be[k]) w[8*k +: 8] = dm_din[8*(k-lo) +: 8];
            mem[dm_addr] <= w;
        end
    end

    always @(negedge clk) if (dm_wr === 1'b1) wr_cnt++;

    // Reference model: flat byte array, little-endian loads/stores.
    byte unsigned ref_mem [0:4095];

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        int nb;
        logic [31:0] v;
        nb = 1 << size;
        v  = 0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(addr[11:0]) + i]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        int nb;
        nb = 1 << size;
        for (int i = 0; i < nb; i++) ref_mem[int'(addr[11:0]) + i] = wd[8*i +: 8];
    endtask

    // Drives one request from IDLE and waits (bounded) for the response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic [1:0] err, output int lat,
                          output logic [3:0] be_a, output logic [9:0] addr_a,
                          output int wr_n, output logic busy_rdy);
        int start_wr;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        start_wr = wr_cnt;
        lat = 0; busy_rdy = 1'b0; be_a = '0; addr_a = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin be_a = dm_be; addr_a = dm_addr; end
            if (req_ready) busy_rdy = 1'b1;
        end while (!resp_valid && lat < 20);
        rdata = resp_rdata;
        err   = resp_err;
        wr_n  = wr_cnt - start_wr;
    endtask

    task automatic finish_resp;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  er;
    int          lt, wn;
    logic [3:0]  bea;
    logic [9:0]  ada;
    logic        bsy;

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if ({resp_rdata, resp_err} !== 34'h0) begin n_fail++; $display("FAIL rst_resp: got %h/%b want 0/00", resp_rdata, resp_err); end
        n_cmp++; if ({dm_wr, dm_be, dm_addr, dm_din, dm_op} !== {1'b0, 4'hF, 10'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL rst_dm: got wr=%b be=%b addr=%h din=%h op=%b want 0/1111/0/0/0", dm_wr, dm_be, dm_addr, dm_din, dm_op);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lt, bea, ada, wn, bsy);
        ref_store(32'h10, 2'b10, 32'hDEADBEEF);
        n_cmp++; if (lt !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lt); end
        n_cmp++; if (bea !== 4'b1111 || ada !== 10'd4) begin n_fail++; $display("FAIL sw_lanes: got be=%b addr=%0d want 1111/4", bea, ada); end
        n_cmp++; if (wn !== 1 || er !== 2'b00 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_resp: got wr=%0d err=%b rdata=%h want 1/00/0", wn, er, rd); end
        n_cmp++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL sw_busy_ready: got %b want 0", bsy); end
        finish_resp();
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 2'b00 || lt !== 3 || wn !== 0) begin
            n_fail++; $display("FAIL lw_resp: got rdata=%h err=%b lat=%0d wr=%0d want deadbeef/00/3/0", rd, er, lt, wn);
        end
        finish_resp();
    endtask

    task automatic test_byte_half;
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, rd, er, lt, bea, ada, wn, bsy);
        ref_store(32'h13, 2'b00, 32'h80);
        n_cmp++; if (bea !== 4'b1000 || ada !== 10'd4 || wn !== 1) begin n_fail++; $display("FAIL sb_lanes: got be=%b addr=%0d wr=%0d want 1000/4/1", bea, ada, wn); end
        finish_resp();
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (rd !== 32'hFFFFFF80 || bea !== 4'b1000) begin n_fail++; $display("FAIL lb: got rdata=%h be=%b want ffffff80/1000", rd, bea); end
        finish_resp();
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", rd); end
        finish_resp();
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, rd, er, lt, bea, ada, wn, bsy);
        ref_store(32'h22, 2'b01, 32'h8001);
        n_cmp++; if (bea !== 4'b1100 || ada !== 10'd8 || wn !== 1) begin n_fail++; $display("FAIL sh_lanes: got be=%b addr=%0d wr=%0d want 1100/8/1", bea, ada, wn); end
        finish_resp();
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: got %h want ffff8001", rd); end
        finish_resp();
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu: got %h want 00008001", rd); end
        finish_resp();
    endtask

    task automatic test_errors;
        do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (er !== 2'b01 || lt !== 1 || wn !== 0 || rd !== 32'h0) begin n_fail++; $display("FAIL lw_misalign: got err=%b lat=%0d wr=%0d rdata=%h want 01/1/0/0", er, lt, wn, rd); end
        finish_resp();
        do_req(1'b1, 2'b01, 1'b0, 32'h1001, 32'h55AA, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (er !== 2'b01 || lt !== 1 || wn !== 0) begin n_fail++; $display("FAIL sh_misalign_prio: got err=%b lat=%0d wr=%0d want 01/1/0", er, lt, wn); end
        finish_resp();
        do_req(1'b1, 2'b11, 1'b0, 32'h1001, 32'h1, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (er !== 2'b11 || lt !== 1 || wn !== 0) begin n_fail++; $display("FAIL size_illegal: got err=%b lat=%0d wr=%0d want 11/1/0", er, lt, wn); end
        finish_resp();
    endtask

    task automatic test_stall;
        logic [31:0] r0;
        logic [1:0]  e0;
        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (er !== 2'b10 || lt !== 1 || wn !== 0) begin n_fail++; $display("FAIL lw_range: got err=%b lat=%0d wr=%0d want 10/1/0", er, lt, wn); end
        r0 = rd; e0 = er;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_rdata !== r0 || resp_err !== e0 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_%0d: got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0", i, resp_valid, resp_rdata, resp_err, req_ready, r0, e0);
            end
        end
        req_valid = 1'b0;
        finish_resp();
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_access;
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, rd, er, lt, bea, ada, wn, bsy);
        ref_store(32'h40, 2'b10, 32'hCAFEF00D);
        finish_resp();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (dm_wr !== 1'b0) begin n_fail++; $display("FAIL rst_access_wr: got %b want 0", dm_wr); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_access_idle: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, bea, ada, wn, bsy);
        n_cmp++; if (rd !== ref_load(32'h40, 2'b10, 1'b0) || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_access_prior: got %h want cafef00d", rd); end
        finish_resp();
    endtask

    task automatic test_random;
        logic        we, uns;
        logic [1:0]  size, e_err;
        logic [31:0] addr, wd, e_rd;
        logic [3:0]  e_be;
        int          mode, nb;
        for (int it = 0; it < 80; it++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 2));
            wd   = $urandom;
            nb   = 1 << size;
            addr = 32'h100 + ($urandom_range(0, 63) & ~(nb - 1));
            mode = $urandom_range(0, 9);
            if (mode == 0) addr = addr | ($urandom_range(1, 32'hFFFFF) << 12);
            if (mode == 1) addr = addr | 32'($urandom_range(0, 3));
            if (mode == 2) size = 2'b11;
            if (size == 2'b11) e_err = 2'b11;
            else if (addr % nb != 0) e_err = 2'b01;
            else if ((addr >> 12) != 0) e_err = 2'b10;
            else e_err = 2'b00;
            e_rd = (e_err == 2'b00 && !we) ? ref_load(addr, size, uns) : 32'h0;
            e_be = 4'(((1 << nb) - 1) << addr[1:0]);
            do_req(we, size, uns, addr, wd, rd, er, lt, bea, ada, wn, bsy);
            if (e_err == 2'b00 && we) ref_store(addr, size, wd);
            n_cmp++;
            if (er !== e_err || rd !== e_rd || lt !== (e_err == 2'b00 ? 3 : 1)
                || wn !== ((e_err == 2'b00 && we) ? 1 : 0)
                || (e_err == 2'b00 && (bea !== e_be || ada !== addr[11:2]))) begin
                n_fail++;
                $display("FAIL rand_%0d: we=%b size=%b addr=%h got err=%b rdata=%h lat=%0d wr=%0d be=%b want %b/%h/be=%b",
                         it, we, size, addr, er, rd, lt, wn, bea, e_err, e_rd, e_be);
            end
            finish_resp();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_stall();
        test_reset_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
